// File: rtl/ysyx_25020047_seq_ctrl_if.sv
// ysyx_25020047_seq_ctrl_if: instruction-fetch and data-memory handshake bundle
interface ysyx_25020047_seq_ctrl_if;
  logic        ifu_req;
  logic        ifu_valid;
  logic [31:0] inst_in;
  logic        lsu_req;
  logic        lsu_wen;
  logic        lsu_valid;
  modport master (output ifu_req, lsu_req, lsu_wen, input ifu_valid, inst_in, lsu_valid);
  modport slave  (input ifu_req, lsu_req, lsu_wen, output ifu_valid, inst_in, lsu_valid);
endinterface

// File: rtl/ysyx_25020047_seq_ctrl.sv
// ysyx_25020047_seq_ctrl: multi-cycle fetch/exec/mem/wb sequencer with hang watchdog
module ysyx_25020047_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          WD_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ysyx_25020047_seq_ctrl_if.master    bus,
  output logic [31:0]                 inst,
  input  logic                        is_load,
  input  logic                        is_store,
  input  logic                        is_ebreak,
  input  logic [31:0]                 dnpc,
  output logic [31:0]                 pc,
  output logic                        rf_we,
  output logic                        halt,
  output logic                        err,
  output logic [31:0]                 retired,
  output logic [2:0]                  state
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, WB, HALT, ERR} state_t;
  state_t          st, nxt;
  logic [WD_W-1:0] wd;
  logic            wd_exp, pc_ok, fetch_done, mem_done, wb_ok;
  assign wd_exp     = &wd;
  assign pc_ok      = dnpc[1:0] == 2'b00;
  assign fetch_done = st == FETCH && bus.ifu_valid;
  assign mem_done   = st == MEM && bus.lsu_valid;
  assign wb_ok      = st == WB && pc_ok;
  // A valid arriving on the last watchdog cycle still wins over the timeout
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = FETCH;
      FETCH:   nxt = bus.ifu_valid ? EXEC : wd_exp ? ERR : FETCH;
      EXEC:    nxt = is_ebreak ? HALT : (is_load | is_store) ? MEM : WB;
      MEM:     nxt = bus.lsu_valid ? WB : wd_exp ? ERR : MEM;
      WB:      nxt = pc_ok ? FETCH : ERR;
      default: nxt = st;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      wd      <= '0;
      pc      <= RESET_PC;
      inst    <= '0;
      retired <= '0;
    end else begin
      st <= nxt;
      wd <= (fetch_done || mem_done) ? '0 : (st == FETCH || st == MEM) ? wd + WD_W'(1) : wd;
      if (fetch_done) inst <= bus.inst_in;
      if (wb_ok) pc <= dnpc;
      if (wb_ok || (st == EXEC && is_ebreak)) retired <= retired + 32'd1;
    end
  end
  assign bus.ifu_req = st == FETCH;
  assign bus.lsu_req = st == MEM;
  assign bus.lsu_wen = st == MEM && is_store;
  assign rf_we       = wb_ok && !is_store;
  assign halt        = st == HALT;
  assign err         = st == ERR;
  assign state       = st;
endmodule

// File: tb/tb_ysyx_25020047_seq_ctrl.sv
// tb_ysyx_25020047_seq_ctrl: randomized instruction stream with per-instruction scoreboard
module tb_ysyx_25020047_seq_ctrl;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  typedef enum int {K_ALU, K_LOAD, K_STORE, K_EBREAK} kind_e;
  typedef struct {
    logic [31:0] pc0, ret0, pc1, ret1, inst;
    int          cyc, lsu, wen, rf, rfpos;
    bit          halt, err;
  } rec_t;

  logic        clk = 0;
  logic        rst_n = 1;
  logic [31:0] inst, pc, retired, dnpc;
  logic        is_load, is_store, is_ebreak, rf_we, halt, err;
  logic [2:0]  state;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] m_pc = RESET_PC, m_ret = 0;
  rec_t        exp_q[$];

  ysyx_25020047_seq_ctrl_if bus();
  ysyx_25020047_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .inst(inst), .is_load(is_load), .is_store(is_store),
    .is_ebreak(is_ebreak), .dnpc(dnpc), .pc(pc), .rf_we(rf_we), .halt(halt), .err(err),
    .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: what one instruction should look like from the outside, given its memory waits
  task automatic model(input kind_e k, input int fw, input int mw, input logic [31:0] dn,
                       input logic [31:0] iw, output rec_t r);
    bit mem = k == K_LOAD || k == K_STORE;
    r = '{pc0: m_pc, ret0: m_ret, pc1: m_pc, ret1: m_ret, inst: iw,
          cyc: 0, lsu: 0, wen: 0, rf: 0, rfpos: 0, halt: 0, err: 0};
    if (fw >= 256) begin
      r.cyc = 256;
      r.err = 1;
    end else begin
      r.cyc = fw + 2;
      if (k == K_EBREAK) begin
        r.halt = 1;
        r.ret1 = m_ret + 1;
      end else begin
        if (mem) begin
          r.lsu = mw >= 256 ? 256 : mw + 1;
          r.wen = k == K_STORE ? r.lsu : 0;
          r.cyc += r.lsu;
        end
        if (mem && mw >= 256) r.err = 1;
        else begin
          r.cyc += 1;
          if (dn[1:0] != 0) r.err = 1;
          else begin
            r.pc1   = dn;
            r.ret1  = m_ret + 1;
            r.rf    = k != K_STORE;
            r.rfpos = r.rf ? r.cyc : 0;
          end
        end
      end
    end
    m_pc  = r.pc1;
    m_ret = r.ret1;
  endtask

  task automatic wait_fetch();
    for (int i = 0; i < 600 && !bus.ifu_req; i++) step();
    check("fetch_req_seen", bus.ifu_req, 1);
  endtask

  task automatic do_inst(input kind_e k, input int fw, input int mw, input logic [31:0] dn);
    logic [31:0] iw = $urandom;
    bit          mem = k == K_LOAD || k == K_STORE;
    rec_t        r;
    model(k, fw, mw, dn, iw, r);
    exp_q.push_back(r);
    wait_fetch();
    repeat (fw) begin
      bus.ifu_valid = 0;
      bus.lsu_valid = 1'($urandom);
      step();
    end
    bus.lsu_valid = 0;
    bus.ifu_valid = 1;
    bus.inst_in   = iw;
    is_load       = k == K_LOAD;
    is_store      = k == K_STORE;
    is_ebreak     = k == K_EBREAK;
    dnpc          = dn;
    step();
    bus.ifu_valid = 0;
    bus.inst_in   = $urandom;
    if (mem) begin
      step();
      repeat (mw) step();
      bus.lsu_valid = 1;
      step();
      bus.lsu_valid = 0;
    end else step();
  endtask

  function automatic logic [31:0] nxt_pc();
    logic [31:0] t = $urandom;
    t[1:0] = 2'b00;
    return $urandom_range(0, 1) ? m_pc + 4 : t;
  endfunction

  task automatic rand_inst();
    do_inst(kind_e'($urandom_range(0, 2)), $urandom_range(0, 3), $urandom_range(0, 5), nxt_pc());
  endtask

  task automatic do_reset();
    rst_n = 0;
    bus.ifu_valid = 0; bus.lsu_valid = 0; bus.inst_in = 0;
    is_load = 0; is_store = 0; is_ebreak = 0; dnpc = 0;
    #2;
    check("rst_state", 32'(state), 0);
    check("rst_pc", pc, RESET_PC);
    check("rst_retired", retired, 0);
    check("rst_inst", inst, 0);
    check("rst_outs", {bus.ifu_req, bus.lsu_req, bus.lsu_wen, rf_we, halt, err}, 0);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    step();
    step();
    rst_n = 1;
    m_pc  = RESET_PC;
    m_ret = 0;
    step();
    check("idle_to_fetch", bus.ifu_req, 1);
  endtask

  task automatic finish_ep(input bit h, input bit e);
    repeat (4) step();
    check("sticky_halt", halt, h);
    check("sticky_err", err, e);
  endtask

  // Monitor: one scoreboard record per instruction, opened at the fetch request edge
  rec_t cur;
  bit   open = 0, prev_req = 0, pend_inst = 0;
  int   cnt, c_lsu, c_wen, c_rf, c_rfpos;

  task automatic close_rec();
    check("cycles", cnt, cur.cyc);
    check("pc_after", pc, cur.pc1);
    check("retired_after", retired, cur.ret1);
    check("lsu_req_cycles", c_lsu, cur.lsu);
    check("lsu_wen_cycles", c_wen, cur.wen);
    check("rf_we_cycles", c_rf, cur.rf);
    check("rf_we_position", c_rfpos, cur.rfpos);
    check("halt_at_end", halt, cur.halt);
    check("err_at_end", err, cur.err);
    open = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      open = 0; prev_req = 0; pend_inst = 0;
    end else begin
      if (pend_inst) begin
        check("inst_latched", inst, cur.inst);
        pend_inst = 0;
      end
      if (open && (halt || err)) close_rec();
      else if (bus.ifu_req && !prev_req) begin
        if (open) close_rec();
        if (exp_q.size() == 0) check("unexpected_fetch", 1, 0);
        else begin
          cur = exp_q.pop_front();
          open = 1;
          cnt = 0; c_lsu = 0; c_wen = 0; c_rf = 0; c_rfpos = 0;
          check("pc_at_fetch", pc, cur.pc0);
          check("retired_at_fetch", retired, cur.ret0);
        end
      end
      if (open) begin
        cnt++;
        if (bus.lsu_req) c_lsu++;
        if (bus.lsu_wen) c_wen++;
        if (rf_we) begin c_rf++; c_rfpos = cnt; end
        if (bus.ifu_req && bus.ifu_valid) pend_inst = 1;
      end else if (halt || err) check("idle_requests", {bus.ifu_req, bus.lsu_req, rf_we}, 0);
      prev_req = bus.ifu_req;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ifu_valid = 0; bus.lsu_valid = 0; bus.inst_in = 0;
    is_load = 0; is_store = 0; is_ebreak = 0; dnpc = 0;
    #2;
    do_reset();
    do_inst(K_ALU, 0, 0, m_pc + 4);
    do_inst(K_LOAD, 0, 5, m_pc + 4);
    do_inst(K_STORE, 1, 2, m_pc + 4);
    do_inst(K_EBREAK, 0, 0, m_pc + 4);
    finish_ep(1, 0);
    do_reset();
    repeat (20) rand_inst();
    do_inst(K_ALU, 0, 0, 32'h8000_0002);
    finish_ep(0, 1);
    do_reset();
    do_inst(K_ALU, 0, 0, m_pc + 4);
    do_inst(K_ALU, 256, 0, 0);
    finish_ep(0, 1);
    do_reset();
    do_inst(K_LOAD, 255, 0, m_pc + 4);
    repeat (5) rand_inst();
    do_inst(K_STORE, 0, 256, 0);
    finish_ep(0, 1);
    do_reset();
    repeat (4) rand_inst();
    begin
      rec_t r;
      model(K_LOAD, 0, 20, m_pc + 4, 32'h0000_2003, r);
      exp_q.push_back(r);
      wait_fetch();
      bus.ifu_valid = 1; bus.inst_in = 32'h0000_2003;
      is_load = 1; is_store = 0; is_ebreak = 0; dnpc = m_pc;
      step();
      bus.ifu_valid = 0;
      repeat (3) step();
      check("mid_mem_lsu_req", bus.lsu_req, 1);
      rst_n = 0;
      #1;
      check("async_rst_state", 32'(state), 0);
      check("async_rst_pc", pc, RESET_PC);
      check("async_rst_lsu_req", bus.lsu_req, 0);
      check("async_rst_retired", retired, 0);
    end
    do_reset();
    repeat (10) rand_inst();
    do_inst(K_EBREAK, 2, 0, 0);
    finish_ep(1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_25020047_seq_ctrl.md
# ysyx_25020047_seq_ctrl

Multi-cycle sequencing controller for the ysyx_25020047 core. It owns the PC and instruction register and steps each instruction through fetch, decode/execute, optional memory access and writeback. It issues request/valid handshakes to the instruction and data memory ports, and produces the register-file and PC write strobes around the writeback unit. It also counts retired instructions, halts on ebreak, and traps hung memory transactions with a watchdog.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- WD_W, 8, watchdog counter width; a wait may last 2^WD_W cycles
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifu_req  out  1  instruction fetch request at address pc
- ifu_valid  in  1  fetch response valid; inst_in sampled this cycle
- inst_in  in  32  fetched instruction word
- inst  out  32  latched instruction register, feeds decoder
- is_load  in  1  decoder: current inst is a load (lw/lbu)
- is_store  in  1  decoder: current inst is a store
- is_ebreak  in  1  decoder: current inst is ebreak
- lsu_req  out  1  data memory request
- lsu_wen  out  1  data memory write enable, valid with lsu_req
- lsu_valid  in  1  data memory response / write ack
- dnpc  in  32  next PC from writeback unit
- pc  out  32  current PC
- rf_we  out  1  register-file write strobe
- halt  out  1  sticky, ebreak reached
- err  out  1  sticky, watchdog timeout or misaligned dnpc
- retired  out  32  retired-instruction count
- state  out  3  FSM state, debug only

## Operation
- States (encoding): IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6.
- Moore outputs:
  - ifu_req = (state==FETCH)
  - lsu_req = (state==MEM)
  - lsu_wen = (state==MEM) & is_store
  - rf_we = (state==WB) & ~is_store & (dnpc[1:0]==0)
  - halt = (state==HALT)
  - err = (state==ERR)
- IDLE: goes to FETCH unconditionally. It is the only state exited by the first edge after reset.
- FETCH: when ifu_valid=1, inst<=inst_in, wd<=0, go to EXEC. Otherwise wd<=wd+1.
- EXEC: one cycle for decode/EXU settle.
  - is_ebreak: go to HALT and increment retired. pc is unchanged.
  - else is_load|is_store: go to MEM.
  - else: go to WB.
  - Priority: ebreak > memory > WB.
- MEM: when lsu_valid=1, wd<=0, go to WB. Otherwise wd<=wd+1.
- WB:
  - dnpc[1:0]==0: pc<=dnpc, retired<=retired+1, go to FETCH.
  - otherwise: go to ERR; pc, retired and rf_we are suppressed.
- Watchdog: in FETCH or MEM, if wd==2^WD_W-1 and the valid input is 0, go to ERR.
  - A valid arriving in that same cycle wins; the instruction proceeds normally.
- HALT and ERR are absorbing. Only rst_n leaves them. All request outputs are 0 there.
- ifu_valid outside FETCH and lsu_valid outside MEM are ignored.
- retired wraps from 32'hFFFF_FFFF to 0 with no flag.

## Timing
- Reset (rst_n=0, async):
  - state=IDLE, pc=RESET_PC, inst=0, wd=0, retired=0.
  - All request and strobe outputs are 0; halt=0, err=0.
- Reset deasserted mid-transaction: any outstanding memory request is abandoned. Memory models must tolerate a dropped request.
- ifu_valid/lsu_valid may assert in the same cycle the request rises (zero-wait memory).
- Latency with zero-wait memory:
  - ALU/jump instruction: 3 cycles (FETCH, EXEC, WB).
  - Load/store: 4 cycles.
  - Each wait cycle adds 1.
- Request hold: requests stay asserted continuously until valid. They drop the cycle after valid is sampled.
- pc, retired and inst update on the rising edge that leaves WB, WB, and FETCH respectively.

## Test plan
- Reset release, zero-wait memory, inst_in=addi, dnpc=pc+4 -> ifu_req high 1 cycle after IDLE; rf_we high exactly in cycle 3 of the instruction; pc=32'h8000_0004; retired=1.
- lw with lsu_valid delayed 5 cycles -> lsu_req high 6 cycles, lsu_wen=0, rf_we 1 cycle after lsu_valid; total 9 cycles.
- Store instruction -> lsu_wen=1 throughout MEM, rf_we=0 in WB, pc advances, retired increments.
- ifu_valid held 0 -> err=1 after exactly 256 FETCH cycles (WD_W=8), sticky until rst_n. Repeat with ifu_valid=1 on cycle 256 -> no error, inst latched.
- ebreak fetched -> halt=1 after EXEC, pc unchanged, retired incremented, no further ifu_req. jal with dnpc=32'h8000_0002 -> err=1, rf_we=0, pc unchanged.
- rst_n pulsed low while in MEM -> immediate state=IDLE, pc=RESET_PC, lsu_req=0, retired=0.
